// File: rtl/decode_hazard_unit.sv
// Decode stage with a small writeback scoreboard that registers the decoded bundle,
// chooses operand forward sources and raises a combinational load-use stall.
module decode_hazard_unit #(
    parameter int INST_BIT_WIDTH = 32,
    parameter int FWD_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [INST_BIT_WIDTH-1:0] inst,
    input  logic                      instValid,
    input  logic                      advance,
    input  logic                      flush,
    output logic                      stall,
    output logic                      decValid,
    output logic [4:0]                sndOpcode,
    output logic [3:0]                dRegAddr,
    output logic [3:0]                s1RegAddr,
    output logic [3:0]                s2RegAddr,
    output logic [31:0]               imm,
    output logic                      regFileWrtEn,
    output logic                      isLoad,
    output logic                      isStore,
    output logic                      isBranch,
    output logic                      isJAL,
    output logic                      illegal,
    output logic [1:0]                s1Fwd,
    output logic [1:0]                s2Fwd,
    output logic                      s2ImmSel
);

    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_ALUI = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b0010;
    localparam logic [3:0] OP_CMPI = 4'b1010;
    localparam logic [3:0] OP_BR   = 4'b0110;
    localparam logic [3:0] OP_LD   = 4'b1001;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_JAL  = 4'b1011;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef struct packed {
        logic        dec_valid;
        logic [4:0]  snd_opcode;
        logic [3:0]  d_addr;
        logic [3:0]  s1_addr;
        logic [3:0]  s2_addr;
        logic [31:0] imm;
        logic        wrt_en;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        illegal;
        logic [1:0]  s1_fwd;
        logic [1:0]  s2_fwd;
        logic        s2_imm_sel;
    } bundle_t;

    typedef struct packed {
        logic       valid;
        logic       wrt_en;
        logic [3:0] d_addr;
        logic       is_load;
    } sb_entry_t;

    // Index 0 of the scoreboard is stage 1 (youngest instruction past decode).
    bundle_t                   bun_q, bun_d, dec_s;
    sb_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
    logic [3:0]                opcode_s;
    logic [3:0]                fn_s;
    logic [31:0]               sext_s;
    logic                      s1_live_s, s2_live_s;
    logic                      load_use_s;
    logic                      stall_s;

    function automatic logic [1:0] fwd_sel(input logic                      live,
                                           input logic [3:0]                addr,
                                           input sb_entry_t [FWD_DEPTH-1:0] sb);
        logic [1:0] sel;
        sel = 2'd0;
        // Walk oldest to youngest so the youngest match is the one left standing.
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            sel = (live && sb[k].valid && sb[k].wrt_en && (sb[k].d_addr == addr)) ? 2'(k + 1) : sel;
        end
        return sel;
    endfunction

    assign opcode_s = inst[INST_BIT_WIDTH-1 -: 4];
    assign fn_s     = inst[27:24];
    assign sext_s   = {{16{inst[15]}}, inst[15:0]};

    // Opcode decode plus forward source selection against the current scoreboard.
    always_comb begin
        dec_s           = '0;
        s1_live_s       = 1'b0;
        s2_live_s       = 1'b0;
        dec_s.dec_valid = 1'b1;
        dec_s.imm       = sext_s;
        case (opcode_s)
            OP_ALU, OP_CMP: begin
                dec_s.d_addr     = inst[23:20];
                dec_s.s1_addr    = inst[19:16];
                dec_s.s2_addr    = inst[15:12];
                dec_s.snd_opcode = {(opcode_s == OP_CMP), fn_s};
                dec_s.wrt_en     = 1'b1;
                s1_live_s        = 1'b1;
                s2_live_s        = 1'b1;
            end
            OP_ALUI, OP_CMPI: begin
                dec_s.d_addr     = inst[23:20];
                dec_s.s1_addr    = inst[19:16];
                dec_s.snd_opcode = {(opcode_s == OP_CMPI), fn_s};
                dec_s.wrt_en     = 1'b1;
                dec_s.s2_imm_sel = 1'b1;
                s1_live_s        = 1'b1;
            end
            OP_BR: begin
                dec_s.s1_addr    = inst[23:20];
                dec_s.s2_addr    = inst[19:16];
                dec_s.snd_opcode = {1'b1, fn_s};
                dec_s.is_branch  = 1'b1;
                s1_live_s        = 1'b1;
                s2_live_s        = 1'b1;
            end
            OP_LD: begin
                dec_s.d_addr     = inst[23:20];
                dec_s.s1_addr    = inst[19:16];
                dec_s.snd_opcode = {1'b0, fn_s};
                dec_s.wrt_en     = 1'b1;
                dec_s.is_load    = 1'b1;
                dec_s.s2_imm_sel = 1'b1;
                s1_live_s        = 1'b1;
            end
            OP_ST: begin
                dec_s.s1_addr    = inst[23:20];
                dec_s.s2_addr    = inst[19:16];
                dec_s.snd_opcode = {1'b0, fn_s};
                dec_s.is_store   = 1'b1;
                dec_s.s2_imm_sel = 1'b1;
                s1_live_s        = 1'b1;
                s2_live_s        = 1'b1;
            end
            OP_JAL: begin
                dec_s.d_addr     = inst[23:20];
                dec_s.s1_addr    = inst[19:16];
                dec_s.snd_opcode = {1'b0, fn_s};
                dec_s.imm        = {sext_s[29:0], 2'b00};
                dec_s.wrt_en     = 1'b1;
                dec_s.is_jal     = 1'b1;
                dec_s.s2_imm_sel = 1'b1;
                s1_live_s        = 1'b1;
            end
            OP_NOP: begin
                dec_s.snd_opcode = 5'b11111;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        dec_s.s1_fwd = fwd_sel(s1_live_s, dec_s.s1_addr, sb_q);
        dec_s.s2_fwd = fwd_sel(s2_live_s, dec_s.s2_addr, sb_q);
    end

    // Load result is not ready for the very next instruction, only from stage 2 on.
    assign load_use_s = sb_q[0].valid && sb_q[0].is_load && sb_q[0].wrt_en &&
                        ((s1_live_s && (sb_q[0].d_addr == dec_s.s1_addr)) ||
                         (s2_live_s && (sb_q[0].d_addr == dec_s.s2_addr)));
    assign stall_s    = instValid && advance && load_use_s;
    assign stall      = stall_s;

    // Next bundle and scoreboard: shift on advance, bubble unless an instruction is accepted.
    always_comb begin
        bun_d = bun_q;
        sb_d  = sb_q;
        if (advance) begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = '0;
            if (flush) begin
                bun_d = '0;
                sb_d  = '0;
            end else if (instValid && !stall_s) begin
                bun_d          = dec_s;
                sb_d[0].valid   = !dec_s.illegal;
                sb_d[0].wrt_en  = dec_s.wrt_en;
                sb_d[0].d_addr  = dec_s.d_addr;
                sb_d[0].is_load = dec_s.is_load;
            end else begin
                bun_d = '0;
            end
        end else begin
            bun_d = bun_q;
            sb_d  = sb_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bun_q <= '0;
            sb_q  <= '0;
        end else begin
            bun_q <= bun_d;
            sb_q  <= sb_d;
        end
    end

    assign decValid     = bun_q.dec_valid;
    assign sndOpcode    = bun_q.snd_opcode;
    assign dRegAddr     = bun_q.d_addr;
    assign s1RegAddr    = bun_q.s1_addr;
    assign s2RegAddr    = bun_q.s2_addr;
    assign imm          = bun_q.imm;
    assign regFileWrtEn = bun_q.wrt_en;
    assign isLoad       = bun_q.is_load;
    assign isStore      = bun_q.is_store;
    assign isBranch     = bun_q.is_branch;
    assign isJAL        = bun_q.is_jal;
    assign illegal      = bun_q.illegal;
    assign s1Fwd        = bun_q.s1_fwd;
    assign s2Fwd        = bun_q.s2_fwd;
    assign s2ImmSel     = bun_q.s2_imm_sel;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed and randomized bench for decode_hazard_unit, checked against an
// opcode-table decoder and a queue of in-flight writebacks.
module tb_decode_hazard_unit;

    localparam int W = 32;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] inst;
    logic        instValid, advance, flush;
    logic        stall, decValid;
    logic [4:0]  sndOpcode;
    logic [3:0]  dRegAddr, s1RegAddr, s2RegAddr;
    logic [31:0] imm;
    logic        regFileWrtEn, isLoad, isStore, isBranch, isJAL, illegal;
    logic [1:0]  s1Fwd, s2Fwd;
    logic        s2ImmSel;

    always #5 clk = ~clk;

    decode_hazard_unit #(.INST_BIT_WIDTH(W), .FWD_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .inst(inst), .instValid(instValid),
        .advance(advance), .flush(flush), .stall(stall), .decValid(decValid),
        .sndOpcode(sndOpcode), .dRegAddr(dRegAddr), .s1RegAddr(s1RegAddr),
        .s2RegAddr(s2RegAddr), .imm(imm), .regFileWrtEn(regFileWrtEn),
        .isLoad(isLoad), .isStore(isStore), .isBranch(isBranch), .isJAL(isJAL),
        .illegal(illegal), .s1Fwd(s1Fwd), .s2Fwd(s2Fwd), .s2ImmSel(s2ImmSel)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  snd;
        logic [3:0]  d, s1, s2;
        logic [31:0] imm;
        logic        wrt, ld, st, br, jal, ill;
        logic [1:0]  s1f, s2f;
        logic        isel;
        logic        s1l, s2l;
    } dec_t;

    typedef struct packed {
        logic       v, w;
        logic [3:0] a;
        logic       l;
    } st_t;

    st_t   stq[$];
    dec_t  exp_b;
    logic  exp_stall;
    logic  last_stall;
    int    checks = 0;
    int    errors = 0;
    string tag;

    function automatic logic [31:0] mk(input logic [3:0] op, f, ra, rb, input logic [15:0] lo);
        return {op, f, ra, rb, lo};
    endfunction

    function automatic dec_t model_decode(input logic [31:0] i);
        dec_t       r;
        logic [3:0] f, ra, rb, rc;
        logic [31:0] se;
        f  = i[27:24]; ra = i[23:20]; rb = i[19:16]; rc = i[15:12];
        se = {{16{i[15]}}, i[15:0]};
        r = '0;
        r.valid = 1'b1;
        r.imm   = (i[31:28] == 4'hB) ? se * 32'd4 : se;
        case (i[31:28])
            4'h0, 4'h2: begin r.d = ra; r.s1 = rb; r.s2 = rc; r.snd = {i[29], f}; r.wrt = 1'b1; r.s1l = 1'b1; r.s2l = 1'b1; end
            4'h8, 4'hA: begin r.d = ra; r.s1 = rb; r.snd = {i[29], f}; r.wrt = 1'b1; r.isel = 1'b1; r.s1l = 1'b1; end
            4'h6: begin r.s1 = ra; r.s2 = rb; r.snd = {1'b1, f}; r.br = 1'b1; r.s1l = 1'b1; r.s2l = 1'b1; end
            4'h9: begin r.d = ra; r.s1 = rb; r.snd = {1'b0, f}; r.wrt = 1'b1; r.ld = 1'b1; r.isel = 1'b1; r.s1l = 1'b1; end
            4'h5: begin r.s1 = ra; r.s2 = rb; r.snd = {1'b0, f}; r.st = 1'b1; r.isel = 1'b1; r.s1l = 1'b1; r.s2l = 1'b1; end
            4'hB: begin r.d = ra; r.s1 = rb; r.snd = {1'b0, f}; r.wrt = 1'b1; r.jal = 1'b1; r.isel = 1'b1; r.s1l = 1'b1; end
            4'hF: r.snd = 5'b11111;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Youngest in-flight writer of the register wins; position in the queue is the stage.
    function automatic logic [1:0] fwd(input logic live, input logic [3:0] a);
        for (int k = 0; k < stq.size(); k++) begin
            if (live && stq[k].v && stq[k].w && stq[k].a == a) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        exp_b = '0;
        stq.delete();
        for (int k = 0; k < D; k++) stq.push_back('0);
    endtask

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s [%s]: observed %h expected %h", t, tag, got, want);
        end
    endtask

    task automatic check_outputs();
        chk("regs", {decValid, sndOpcode, dRegAddr, s1RegAddr, s2RegAddr},
            {exp_b.valid, exp_b.snd, exp_b.d, exp_b.s1, exp_b.s2});
        chk("flags", {regFileWrtEn, isLoad, isStore, isBranch, isJAL, illegal},
            {exp_b.wrt, exp_b.ld, exp_b.st, exp_b.br, exp_b.jal, exp_b.ill});
        chk("imm", imm, exp_b.imm);
        chk("fwd", {s1Fwd, s2Fwd, s2ImmSel}, {exp_b.s1f, exp_b.s2f, exp_b.isel});
    endtask

    // One clock: drive, check the combinational stall, clock, advance the model, check the bundle.
    task automatic step(input logic [31:0] i, input logic iv, adv, fl);
        dec_t d;
        inst = i; instValid = iv; advance = adv; flush = fl;
        #1;
        d = model_decode(i);
        exp_stall = iv && adv && stq[0].v && stq[0].l && stq[0].w &&
                    ((d.s1l && stq[0].a == d.s1) || (d.s2l && stq[0].a == d.s2));
        chk("stall", stall, exp_stall);
        @(posedge clk);
        #1;
        if (adv) begin
            if (fl) begin
                exp_b = '0;
                foreach (stq[k]) stq[k] = '0;
            end else if (iv && !exp_stall) begin
                d.s1f = fwd(d.s1l, d.s1);
                d.s2f = fwd(d.s2l, d.s2);
                stq.push_front({~d.ill, d.wrt, d.d, d.ld});
                void'(stq.pop_back());
                d.s1l = 1'b0; d.s2l = 1'b0;
                exp_b = d;
            end else begin
                exp_b = '0;
                stq.push_front('0);
                void'(stq.pop_back());
            end
        end
        check_outputs();
        last_stall = exp_stall && adv && !fl;
    endtask

    logic [3:0] ops [11] = '{4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'h9, 4'h5, 4'hB, 4'hF, 4'h3, 4'hC};
    logic [31:0] r_inst;

    initial begin
        reset_n = 1'b0; inst = '0; instValid = 1'b0; advance = 1'b0; flush = 1'b0;
        last_stall = 1'b0;
        model_reset();
        tag = "reset";
        #2;
        check_outputs();
        chk("reset_stall", stall, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        tag = "alu_chain";
        step(mk(4'h0, 4'h0, 4'd3, 4'd1, 16'h2000), 1'b1, 1'b1, 1'b0);
        step(mk(4'h0, 4'h0, 4'd4, 4'd3, 16'h3000), 1'b1, 1'b1, 1'b0);
        chk("alu_chain_fwd", {s1Fwd, s2Fwd}, 4'b0101);

        tag = "load_use";
        step(mk(4'h9, 4'h0, 4'd5, 4'd1, 16'h0004), 1'b1, 1'b1, 1'b0);
        step(mk(4'h0, 4'h0, 4'd6, 4'd5, 16'h1000), 1'b1, 1'b1, 1'b0);
        chk("load_use_stall", {exp_stall, decValid}, 2'b10);
        step(mk(4'h0, 4'h0, 4'd6, 4'd5, 16'h1000), 1'b1, 1'b1, 1'b0);
        chk("load_use_fwd", {s1Fwd, s2Fwd}, 4'b1000);

        tag = "alu_imm";
        step(mk(4'h0, 4'h0, 4'd0, 4'd1, 16'h2000), 1'b1, 1'b1, 1'b0);
        step(mk(4'h8, 4'h0, 4'd7, 4'd2, 16'hFFFC), 1'b1, 1'b1, 1'b0);
        chk("alu_imm_val", {imm, s2ImmSel, s2RegAddr, s2Fwd}, {32'hFFFFFFFC, 1'b1, 4'd0, 2'd0});

        tag = "jal";
        step(mk(4'hB, 4'h0, 4'd1, 4'd0, 16'h8001), 1'b1, 1'b1, 1'b0);
        chk("jal_val", {imm, isJAL, isLoad, isStore}, {32'hFFFE0004, 1'b1, 1'b0, 1'b0});

        tag = "flush_stall";
        step(mk(4'h9, 4'h0, 4'd5, 4'd1, 16'h0004), 1'b1, 1'b1, 1'b0);
        step(mk(4'h0, 4'h0, 4'd6, 4'd5, 16'h1000), 1'b1, 1'b1, 1'b1);
        step(mk(4'h0, 4'h0, 4'd6, 4'd5, 16'h1000), 1'b1, 1'b1, 1'b0);
        chk("flush_then_nofwd", {stall, s1Fwd, s2Fwd}, 5'b0);

        tag = "reset_in_stall";
        step(mk(4'h9, 4'h0, 4'd5, 4'd1, 16'h0004), 1'b1, 1'b1, 1'b0);
        inst = mk(4'h0, 4'h0, 4'd6, 4'd5, 16'h1000); instValid = 1'b1; advance = 1'b1; flush = 1'b0;
        #1;
        chk("pre_reset_stall", stall, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("reset_stall_clear", stall, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(mk(4'h0, 4'h0, 4'd6, 4'd5, 16'h1000), 1'b1, 1'b1, 1'b0);
        chk("post_reset_nofwd", {s1Fwd, s2Fwd, decValid}, 5'b00001);

        tag = "random";
        r_inst = '0;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                r_inst = mk(ops[$urandom_range(0, 10)], 4'($urandom_range(0, 15)),
                            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 16'($urandom));
                r_inst[15:12] = 4'($urandom_range(0, 3));
            end
            step(r_inst, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_hazard_unit.md
DECODE_HAZARD_UNIT -- requirements
Module: decode_hazard_unit

Interface
REQ-001 Parameter INST_BIT_WIDTH, default 32, instruction word width; opcode in [INST_BIT_WIDTH-1:INST_BIT_WIDTH-4].
REQ-002 Parameter FWD_DEPTH, default 2, legal 1..3, number of downstream writeback stages tracked for forwarding.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 inst / instValid  in  INST_BIT_WIDTH / 1  fetched instruction and its qualifier.
REQ-006 advance  in  1  downstream accepts; when 0 every register holds.
REQ-007 flush  in  1  discard in-flight decode (taken branch / JAL redirect).
REQ-008 stall  out  1  combinational load-use stall; fetch holds inst while high.
REQ-009 decValid, sndOpcode[4:0], dRegAddr/s1RegAddr/s2RegAddr[3:0], imm[31:0], regFileWrtEn, isLoad, isStore, isBranch, isJAL, illegal  out  registered decode bundle.
REQ-010 s1Fwd[1:0], s2Fwd[1:0]  out  registered forward source: 0 = register file, k = stage k (1 youngest); s2ImmSel  out  1  registered, operand 2 from imm.

Function
REQ-011 Decode by opcode: 0000 ALU (d,s1,s2 = [23:20],[19:16],[15:12]; sndOpcode {0,[27:24]}); 1000 ALU-imm; 0010 compare ({1,[27:24]}); 1010 compare-imm; 0110 branch (s1=[23:20], s2=[19:16], {1,[27:24]}); 1001 load; 0101 store (s1=[23:20], s2=[19:16]); 1011 JAL; 1111 NOOP (sndOpcode 11111); all others illegal.
REQ-012 imm SHALL be inst[15:0] sign-extended to 32 bits; for JAL sign-extended then shifted left 2.
REQ-013 regFileWrtEn = 1 for ALU, ALU-imm, compare, compare-imm, load, JAL; else 0.
REQ-014 Source use: s1 live for all except NOOP/illegal; s2 live only for ALU, compare, branch, store; unused address outputs SHALL be 0 and never trigger forward or stall.
REQ-015 s2ImmSel = 1 for ALU-imm, compare-imm, load, store, JAL.
REQ-016 Scoreboard: FWD_DEPTH entries {valid, wrtEn, dRegAddr, isLoad}; on each advance edge entry k+1 <= entry k, entry 1 <= current decoded instruction (or bubble), oldest discarded.
REQ-017 Forward select per live source: youngest valid entry with wrtEn=1 and matching address wins; no match -> 0.
REQ-018 stall = instValid & advance & entry1.valid & entry1.isLoad & entry1.wrtEn & (entry1.dRegAddr matches any live source).
REQ-019 Latency: decode bundle valid one cycle after the edge accepting inst (instValid=1, advance=1, stall=0, flush=0).
REQ-020 On stall edge: bubble inserted (decValid=0, entry1 invalid), inst not consumed; re-decoded next cycle with forward from stage 2 (FWD_DEPTH>=2) or 0 (FWD_DEPTH=1, regfile written).
REQ-021 On flush edge: decValid <= 0, all scoreboard entries invalid; flush overrides stall and instValid.
REQ-022 Illegal opcode: decValid <= 1, illegal <= 1 for one bundle, regFileWrtEn/isLoad/isStore/isBranch/isJAL = 0, scoreboard entry invalid.
REQ-023 instValid=0 with advance=1: bubble entered, decValid <= 0.
REQ-024 advance=0: outputs and scoreboard hold; stall forced 0.

Reset
REQ-025 reset_n low SHALL asynchronously clear all outputs to 0 (sndOpcode 00000, imm 0, s1Fwd/s2Fwd 00) and invalidate all scoreboard entries.
REQ-026 Reset deasserted mid-stream: first accepted instruction sees no forwarding and no stall.

Verification
REQ-027 ALU r3<=r1+r2 then ALU r4<=r3+r3, advance=1 -> second bundle s1Fwd=1, s2Fwd=1, stall=0.
REQ-028 Load r5 then ALU r6<=r5+r1 -> stall=1 one cycle, bubble, then s1Fwd=2 (FWD_DEPTH=2), s2Fwd=0.
REQ-029 ALU-imm r7<=r2+0xFFFC -> imm=0xFFFFFFFC, s2ImmSel=1, s2RegAddr=0, s2Fwd=0 even if stage 1 writes r0.
REQ-030 JAL with inst[15:0]=0x8001 -> imm=0xFFFE0004, isJAL=1, memory flags 0.
REQ-031 Flush asserted same cycle as stall -> next cycle decValid=0, scoreboard empty, stall=0.
REQ-032 reset_n low during a stall -> all outputs 0 immediately, no forward on first post-reset instruction.
